// File: rtl/ec_point_unit.sv
// rtl/ec_point_unit.sv - EC point add/sub/double sequencer over shared mul/mod/inv units
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, op                launch (accepted only in IDLE); 00 add, 01 sub, 10 double, 11 reserved
//   p_pt, q_pt               operands {inf, y, x}, coordinates reduced
//   modulus, curve_a         prime p and curve coefficient a, latched with start
//   busy, done, err, r_pt    status, one-cycle done pulse, reserved-op flag, held result
//   mul_*, mod_*, inv_*      req/operand/done/result handshakes to the shared arithmetic units
module ec_point_unit #(
  parameter int W  = 64,
  parameter int PW = 2*W+1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [PW-1:0]   p_pt,
  input  logic [PW-1:0]   q_pt,
  input  logic [W-1:0]    modulus,
  input  logic [W-1:0]    curve_a,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [PW-1:0]   r_pt,
  output logic            mul_req,
  output logic [W-1:0]    mul_a,
  output logic [W-1:0]    mul_b,
  input  logic            mul_done,
  input  logic [2*W-1:0]  mul_res,
  output logic            mod_req,
  output logic [2*W+3:0]  mod_a,
  input  logic            mod_done,
  input  logic [W-1:0]    mod_res,
  output logic            inv_req,
  output logic [W-1:0]    inv_a,
  input  logic            inv_done,
  input  logic [W-1:0]    inv_res
);

  localparam int MW = 2*W+4;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DBL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [PW-1:0] PT_INF = PW'(1) << (2*W);

  typedef enum logic [3:0] {
    S_IDLE, S_CLASSIFY, S_DY, S_DX, S_SQ, S_NUM, S_DEN, S_INV,
    S_LM, S_LR, S_L2, S_XR, S_YM, S_YR, S_DONE
  } state_t;

  state_t state, next_state, cls_next;

  // Latched operands and intermediates
  logic [W-1:0]   px, py, qx, qy, mod_r, a_r;
  logic           p_inf, q_inf, dbl_r, err_r, fresh;
  logic [1:0]     op_r;
  logic [W-1:0]   num_r, den_r, inv_r, lam_r, rx_r;
  logic [2*W-1:0] prod_r;

  logic [W-1:0]   qyp, ym_b;
  logic [PW-1:0]  cls_res;
  logic           cls_dbl;
  logic [MW-1:0]  ext_px, ext_py, ext_qx, ext_qyp, ext_prod, ext_a, ext_x2;

  // Effective Q.y: negated for subtraction, with -0 kept at 0
  assign qyp = (op_r == OP_SUB) ? ((qy == '0) ? '0 : mod_r - qy) : qy;

  // Px - Rx brought into [0,p) with a single conditional add so it fits the
  // W-bit multiplier port; congruent to Px - Rx + p, so the residue is unchanged.
  assign ym_b = (px >= rx_r) ? px - rx_r : px + (mod_r - rx_r);

  // Operands are non-negative, so zero-extension is the sign-extension;
  // differences are then formed in full MW-bit two's complement.
  assign ext_px   = MW'(px);
  assign ext_py   = MW'(py);
  assign ext_qx   = MW'(qx);
  assign ext_qyp  = MW'(qyp);
  assign ext_prod = MW'(prod_r);
  assign ext_a    = MW'(a_r);
  assign ext_x2   = dbl_r ? ext_px : ext_qx;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Operand classification, evaluated during CLASSIFY
  always_comb begin
    cls_next = S_DONE;
    cls_res  = '0;
    cls_dbl  = 1'b0;
    if (op_r == OP_RSV) begin
      cls_res = '0;
    end else if (op_r == OP_DBL) begin
      if (p_inf || py == '0) cls_res = PT_INF;
      else begin
        cls_next = S_SQ;
        cls_dbl  = 1'b1;
      end
    end else if (p_inf && q_inf) begin
      cls_res = PT_INF;
    end else if (p_inf) begin
      cls_res = PW'({1'b0, qyp, qx});
    end else if (q_inf) begin
      cls_res = PW'({1'b0, py, px});
    end else if (px == qx) begin
      if (py == qyp) begin
        cls_next = S_SQ;
        cls_dbl  = 1'b1;
      end else begin
        cls_res = PT_INF;
      end
    end else begin
      cls_next = S_DY;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start) next_state = S_CLASSIFY;
      S_CLASSIFY: next_state = cls_next;
      S_DY:       if (mod_done) next_state = S_DX;
      S_DX:       if (mod_done) next_state = S_INV;
      S_SQ:       if (mul_done) next_state = S_NUM;
      S_NUM:      if (mod_done) next_state = S_DEN;
      S_DEN:      if (mod_done) next_state = S_INV;
      S_INV:      if (inv_done) next_state = S_LM;
      S_LM:       if (mul_done) next_state = S_LR;
      S_LR:       if (mod_done) next_state = S_L2;
      S_L2:       if (mul_done) next_state = S_XR;
      S_XR:       if (mod_done) next_state = S_YM;
      S_YM:       if (mul_done) next_state = S_YR;
      S_YR:       if (mod_done) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Outputs: requests pulse on the entry cycle (fresh), operands held all state long
  always_comb begin
    busy    = (state != S_IDLE) && (state != S_DONE);
    done    = (state == S_DONE);
    err     = (state == S_DONE) && err_r;
    mul_req = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    mod_req = 1'b0;
    mod_a   = '0;
    inv_req = 1'b0;
    inv_a   = '0;
    case (state)
      S_DY:  begin mod_req = fresh; mod_a = ext_qyp - ext_py; end
      S_DX:  begin mod_req = fresh; mod_a = ext_qx - ext_px; end
      S_SQ:  begin mul_req = fresh; mul_a = px; mul_b = px; end
      S_NUM: begin mod_req = fresh; mod_a = (ext_prod << 1) + ext_prod + ext_a; end
      S_DEN: begin mod_req = fresh; mod_a = ext_py << 1; end
      S_INV: begin inv_req = fresh; inv_a = den_r; end
      S_LM:  begin mul_req = fresh; mul_a = num_r; mul_b = inv_r; end
      S_LR:  begin mod_req = fresh; mod_a = ext_prod; end
      S_L2:  begin mul_req = fresh; mul_a = lam_r; mul_b = lam_r; end
      S_XR:  begin mod_req = fresh; mod_a = ext_prod - ext_px - ext_x2; end
      S_YM:  begin mul_req = fresh; mul_a = lam_r; mul_b = ym_b; end
      S_YR:  begin mod_req = fresh; mod_a = ext_prod - ext_py; end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh  <= 1'b0;
      px     <= '0;
      py     <= '0;
      qx     <= '0;
      qy     <= '0;
      p_inf  <= 1'b0;
      q_inf  <= 1'b0;
      op_r   <= '0;
      mod_r  <= '0;
      a_r    <= '0;
      dbl_r  <= 1'b0;
      err_r  <= 1'b0;
      num_r  <= '0;
      den_r  <= '0;
      inv_r  <= '0;
      lam_r  <= '0;
      rx_r   <= '0;
      prod_r <= '0;
      r_pt   <= '0;
    end else begin
      fresh <= (next_state != state);
      case (state)
        S_IDLE: if (start) begin
          px    <= p_pt[W-1:0];
          py    <= p_pt[2*W-1:W];
          p_inf <= p_pt[2*W];
          qx    <= q_pt[W-1:0];
          qy    <= q_pt[2*W-1:W];
          q_inf <= q_pt[2*W];
          op_r  <= op;
          mod_r <= modulus;
          a_r   <= curve_a;
        end
        S_CLASSIFY: begin
          dbl_r <= cls_dbl;
          err_r <= (op_r == OP_RSV);
          if (cls_next == S_DONE) r_pt <= cls_res;
        end
        S_DY, S_NUM:               if (mod_done) num_r  <= mod_res;
        S_DX, S_DEN:               if (mod_done) den_r  <= mod_res;
        S_SQ, S_LM, S_L2, S_YM:    if (mul_done) prod_r <= mul_res;
        S_INV:                     if (inv_done) inv_r  <= inv_res;
        S_LR:                      if (mod_done) lam_r  <= mod_res;
        S_XR:                      if (mod_done) rx_r   <= mod_res;
        S_YR:                      if (mod_done) r_pt   <= PW'({1'b0, mod_res, rx_r});
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ec_point_unit.sv
// tb/tb_ec_point_unit.sv - randomized self-checking bench for ec_point_unit against an affine-arithmetic model
module tb_ec_point_unit;

  localparam int W  = 8;
  localparam int PW = 2*W+1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      op = '0;
  logic [PW-1:0]   p_pt = '0, q_pt = '0;
  logic [W-1:0]    modulus = '0, curve_a = '0;
  logic            busy, done, err;
  logic [PW-1:0]   r_pt;
  logic            mul_req, mod_req, inv_req;
  logic [W-1:0]    mul_a, mul_b, inv_a;
  logic [2*W+3:0]  mod_a;
  logic            mul_done = 1'b0, mod_done = 1'b0, inv_done = 1'b0;
  logic [2*W-1:0]  mul_res = '0;
  logic [W-1:0]    mod_res = '0, inv_res = '0;

  ec_point_unit #(.W(W), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .p_pt(p_pt), .q_pt(q_pt),
    .modulus(modulus), .curve_a(curve_a), .busy(busy), .done(done), .err(err), .r_pt(r_pt),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_res(mul_res),
    .mod_req(mod_req), .mod_a(mod_a), .mod_done(mod_done), .mod_res(mod_res),
    .inv_req(inv_req), .inv_a(inv_a), .inv_done(inv_done), .inv_res(inv_res)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_p    = 17;
  int n_mul = 0, n_mod = 0, n_inv = 0, inv_at_mul = 0;
  int last_mul_before = 0;
  logic [PW-1:0] last_exp = '0;
  logic [PW-1:0] INF = {1'b1, {(2*W){1'b0}}};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int md(input longint v, input int p);
    longint r;
    r = v % p;
    if (r < 0) r += p;
    return int'(r);
  endfunction

  function automatic int inv_m(input int v, input int p);
    for (int i = 1; i < p; i++)
      if ((v * i) % p == 1) return i;
    return 0;
  endfunction

  function automatic logic [PW-1:0] pt(input int x, input int y, input bit inf);
    return {inf, y[W-1:0], x[W-1:0]};
  endfunction

  // Affine group law; path: 0 = no unit work, 1 = chord, 2 = tangent
  function automatic logic [PW-1:0] ref_ec(input logic [1:0] o, input logic [PW-1:0] P, input logic [PW-1:0] Q,
                                           input int p, input int a, output int path);
    longint px, py, qx, qy, lam, rx, ry;
    bit pi, qi, dbl;
    path = 0;
    dbl  = 0;
    if (o == 2'b11) return '0;
    px = longint'(P[W-1:0]); py = longint'(P[2*W-1:W]); pi = P[2*W];
    qx = longint'(Q[W-1:0]); qy = longint'(Q[2*W-1:W]); qi = Q[2*W];
    if (o == 2'b10) begin
      if (pi || py == 0) return INF;
      dbl = 1;
    end else begin
      if (o == 2'b01) qy = md(-qy, p);
      if (pi && qi) return INF;
      if (pi) return {1'b0, qy[W-1:0], qx[W-1:0]};
      if (qi) return P;
      if (px == qx) begin
        if (py == qy) dbl = 1;
        else return INF;
      end
    end
    if (dbl) begin
      path = 2;
      lam  = md((3*px*px + a) * inv_m(md(2*py, p), p), p);
      qx   = px;
    end else begin
      path = 1;
      lam  = md(md(qy - py, p) * inv_m(md(qx - px, p), p), p);
    end
    rx = md(lam*lam - px - qx, p);
    ry = md(lam*(px - rx) - py, p);
    return {1'b0, ry[W-1:0], rx[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (mul_req) n_mul++;
    if (mod_req) n_mod++;
    if (inv_req) begin
      inv_at_mul = n_mul;
      n_inv++;
    end
  end

  // External unit models with 1..5 cycle latency
  initial begin : mul_unit
    int n;
    logic [W-1:0] a, b;
    @(negedge clk);
    forever begin
      if (mul_req) begin
        a = mul_a; b = mul_b;
        n = $urandom_range(1, 5);
        repeat (n) @(negedge clk);
        check_eq("mul_hold", {mul_a, mul_b}, {a, b});
        mul_res  = (2*W)'(a) * (2*W)'(b);
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
      end else @(negedge clk);
    end
  end

  initial begin : mod_unit
    int n;
    logic [2*W+3:0] v;
    @(negedge clk);
    forever begin
      if (mod_req) begin
        v = mod_a;
        n = $urandom_range(1, 5);
        repeat (n) @(negedge clk);
        check_eq("mod_hold", mod_a, v);
        mod_res  = W'(md(longint'($signed(v)), cur_p));
        mod_done = 1'b1;
        @(negedge clk);
        mod_done = 1'b0;
      end else @(negedge clk);
    end
  end

  initial begin : inv_unit
    int n;
    logic [W-1:0] v;
    @(negedge clk);
    forever begin
      if (inv_req) begin
        v = inv_a;
        n = $urandom_range(1, 5);
        repeat (n) @(negedge clk);
        inv_res  = W'(inv_m(int'(v), cur_p));
        inv_done = 1'b1;
        @(negedge clk);
        inv_done = 1'b0;
      end else @(negedge clk);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [PW-1:0] P, input logic [PW-1:0] Q,
                        input int p, input int a, input bit poke, input string tag,
                        input logic [PW-1:0] exp_in, input bit has_exp);
    logic [PW-1:0] exp;
    int path, bm, bmo, bi, cyc;
    bit held_bad;
    exp = ref_ec(o, P, Q, p, a, path);
    if (has_exp) exp = exp_in;
    @(negedge clk);
    cur_p = p; op = o; p_pt = P; q_pt = Q;
    modulus = W'(p); curve_a = W'(a); start = 1'b1;
    bm = n_mul; bmo = n_mod; bi = n_inv;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".busy"}, busy, 1);
    cyc = 0;
    held_bad = 0;
    while (!done && cyc < 400) begin
      if (r_pt !== last_exp) held_bad = 1;
      if (poke && cyc == 2) begin start = 1'b1; op = 2'b00; p_pt = pt(1, 2, 0); q_pt = pt(3, 4, 0); end
      if (poke && cyc == 3) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq({tag, ".done"}, done, 1);
    check_eq({tag, ".r_pt"}, r_pt, exp);
    check_eq({tag, ".err"}, err, (o == 2'b11));
    check_eq({tag, ".busy_at_done"}, busy, 0);
    check_eq({tag, ".r_held"}, held_bad, 0);
    check_eq({tag, ".n_mul"}, n_mul - bm, (path == 2) ? 4 : (path == 1) ? 3 : 0);
    check_eq({tag, ".n_mod"}, n_mod - bmo, (path != 0) ? 5 : 0);
    check_eq({tag, ".n_inv"}, n_inv - bi, (path != 0) ? 1 : 0);
    last_mul_before = inv_at_mul - bm;
    last_exp = exp;
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, done, 0);
    check_eq({tag, ".idle_after"}, busy, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    bit bad;
    int primes[5] = '{17, 251, 13, 101, 233};
    repeat (3) @(negedge clk);
    check_eq("reset.status", {busy, done, err}, 3'b000);
    check_eq("reset.r_pt", r_pt, 0);
    check_eq("reset.reqs", {mul_req, mod_req, inv_req}, 3'b000);
    check_eq("reset.buses", {mul_a, mul_b, inv_a, mod_a}, 0);
    rst = 1'b0;

    run_op(2'b10, pt(5, 1, 0), pt(0, 0, 0), 17, 2, 0, "dbl", pt(6, 3, 0), 1);
    check_eq("dbl.mul_before_inv", last_mul_before, 1);
    run_op(2'b00, pt(5, 1, 0), pt(6, 3, 0), 17, 2, 0, "add", pt(10, 6, 0), 1);
    run_op(2'b01, pt(10, 6, 0), pt(6, 3, 0), 17, 2, 0, "sub", pt(5, 1, 0), 1);
    run_op(2'b00, pt(5, 1, 0), pt(5, 1, 0), 17, 2, 0, "add_eq", pt(6, 3, 0), 1);
    run_op(2'b00, pt(5, 1, 0), pt(5, 16, 0), 17, 2, 0, "add_neg", INF, 1);
    run_op(2'b01, pt(0, 0, 1), pt(6, 3, 0), 17, 2, 0, "sub_pinf", pt(6, 14, 0), 1);
    run_op(2'b00, pt(5, 1, 0), pt(0, 0, 1), 17, 2, 0, "add_qinf", pt(5, 1, 0), 1);
    run_op(2'b10, pt(0, 0, 1), pt(0, 0, 0), 17, 2, 0, "dbl_inf", INF, 1);
    run_op(2'b11, pt(5, 1, 0), pt(6, 3, 0), 17, 2, 0, "rsv", '0, 1);
    run_op(2'b00, pt(5, 1, 0), pt(6, 3, 0), 17, 2, 1, "busy_start", pt(10, 6, 0), 1);

    // Reset while waiting on the inverter, then a late inv_done arrives
    @(negedge clk);
    cur_p = 17; op = 2'b10; p_pt = pt(5, 1, 0); modulus = 8'd17; curve_a = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!inv_req && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_mid.inv_wait", inv_req, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid.status", {busy, done, err}, 3'b000);
    check_eq("rst_mid.r_pt", r_pt, 0);
    check_eq("rst_mid.reqs", {mul_req, mod_req, inv_req}, 3'b000);
    check_eq("rst_mid.buses", {mul_a, mul_b, inv_a, mod_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || done || mul_req || mod_req || inv_req) bad = 1;
    end
    check_eq("rst_mid.quiet", bad, 0);
    check_eq("rst_mid.r_pt_after", r_pt, 0);
    last_exp = '0;
    run_op(2'b00, pt(5, 1, 0), pt(6, 3, 0), 17, 2, 0, "post_rst", pt(10, 6, 0), 1);

    for (int i = 0; i < 40; i++) begin
      int p, a, sel;
      logic [1:0] o;
      logic [PW-1:0] P, Q;
      p = primes[$urandom_range(0, 4)];
      a = $urandom_range(0, p - 1);
      o = 2'($urandom_range(0, 3));
      P = pt($urandom_range(0, p - 1), $urandom_range(1, p - 1), $urandom_range(0, 7) == 0);
      Q = pt($urandom_range(0, p - 1), $urandom_range(1, p - 1), $urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 5);
      if (sel == 0) Q = P;
      if (sel == 1) Q = pt(int'(P[W-1:0]), p - int'(P[2*W-1:W]), 0);
      run_op(o, P, Q, p, a, 0, "rand", '0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
